// File: rtl/cc1200_spi_slave.sv
// CC1200-style SPI slave: mode 0 header/data framing, 47-byte register file, command strobes.
// Optional burst addressing is enabled with macro CC1200_SPI_BURST_EN.
module cc1200_spi_slave #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = 47
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       cs_n,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] status_i,
  output logic       wr_strobe,
  output logic [5:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       cmd_strobe,
  output logic [5:0] cmd,
  input  logic [5:0] reg_addr_i,
  output logic [7:0] reg_data_o,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    DATA,
    IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] r_sclk_s;
  logic [SYNC_STAGES-1:0] r_mosi_s;
  logic [SYNC_STAGES-1:0] r_csn_s;
  logic [SYNC_STAGES-1:0] r_vld_s;
  logic                   r_sclk_q;
  logic                   r_csn_q;

  state_t     r_state;
  logic [2:0] r_bitcnt;
  logic [7:0] r_rx;
  logic [7:0] r_tx;
  logic [5:0] r_addr;
  logic       r_rw;
  logic       r_load;
`ifdef CC1200_SPI_BURST_EN
  logic       r_burst;
`endif
  logic       r_miso;
  logic       r_oe;
  logic       r_busy;
  logic       r_wr_strobe;
  logic [5:0] r_wr_addr;
  logic [7:0] r_wr_data;
  logic       r_cmd_strobe;
  logic [5:0] r_cmd;
  logic [7:0] r_regs [NUM_REGS];

  logic       w_sclk;
  logic       w_mosi;
  logic       w_csn;
  logic       w_rise;
  logic       w_fall;
  logic       w_open;
  logic [7:0] w_byte;
  logic [5:0] w_hdr_addr;
  logic       w_is_cmd;
  logic       w_last;
  logic       w_wr_ok;
  logic [7:0] w_rd_data;

  function automatic logic f_rd_ok(input logic [5:0] a);
    return !(a == 6'h2F || a == 6'h3E || a == 6'h3F) &&
           ({26'd0, a} < 32'(NUM_REGS));
  endfunction

  // r_vld_s marks when the chains hold real samples, not the reset preset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_s <= '0;
      r_mosi_s <= '0;
      r_csn_s  <= '1;
      r_vld_s  <= '0;
      r_sclk_q <= 1'b0;
      r_csn_q  <= 1'b0;
    end else begin
      r_sclk_s[0] <= sclk;
      r_mosi_s[0] <= mosi;
      r_csn_s[0]  <= cs_n;
      r_vld_s[0]  <= 1'b1;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sclk_s[i] <= r_sclk_s[i-1];
        r_mosi_s[i] <= r_mosi_s[i-1];
        r_csn_s[i]  <= r_csn_s[i-1];
        r_vld_s[i]  <= r_vld_s[i-1];
      end
      r_sclk_q <= w_sclk;
      r_csn_q  <= w_csn & r_vld_s[SYNC_STAGES-1];
    end
  end

  assign w_sclk     = r_sclk_s[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_s[SYNC_STAGES-1];
  assign w_csn      = r_csn_s[SYNC_STAGES-1];
  assign w_rise     = w_sclk & ~r_sclk_q;
  assign w_fall     = ~w_sclk & r_sclk_q;
  assign w_open     = ~w_csn & r_csn_q;
  assign w_byte     = {r_rx[6:0], w_mosi};
  assign w_hdr_addr = w_byte[5:0];
  assign w_is_cmd   = (w_hdr_addr >= 6'h30) && (w_hdr_addr <= 6'h3D);
  assign w_last     = (r_bitcnt == 3'd7);
  assign w_wr_ok    = ({26'd0, r_addr} < 32'(NUM_REGS));

  always_comb begin
    w_rd_data = 8'h00;
    if (f_rd_ok(r_addr)) w_rd_data = r_regs[r_addr];
  end

  always_comb begin
    reg_data_o = 8'h00;
    if (f_rd_ok(reg_addr_i)) reg_data_o = r_regs[reg_addr_i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_bitcnt     <= 3'd0;
      r_rx         <= 8'h00;
      r_tx         <= 8'h00;
      r_addr       <= 6'd0;
      r_rw         <= 1'b0;
      r_load       <= 1'b0;
`ifdef CC1200_SPI_BURST_EN
      r_burst      <= 1'b0;
`endif
      r_miso       <= 1'b0;
      r_oe         <= 1'b0;
      r_busy       <= 1'b0;
      r_wr_strobe  <= 1'b0;
      r_wr_addr    <= 6'd0;
      r_wr_data    <= 8'h00;
      r_cmd_strobe <= 1'b0;
      r_cmd        <= 6'd0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 8'h00;
    end else begin
      r_wr_strobe  <= 1'b0;
      r_cmd_strobe <= 1'b0;
      // cs_n high wins over any edge, so a completing byte is dropped
      if (r_state != IDLE && w_csn) begin
        r_state <= IDLE;
        r_miso  <= 1'b0;
        r_oe    <= 1'b0;
        r_busy  <= 1'b0;
        r_load  <= 1'b0;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (w_open) begin
              r_state  <= HEADER;
              r_bitcnt <= 3'd0;
              r_tx     <= status_i;
              r_miso   <= status_i[7];
              r_oe     <= 1'b1;
              r_busy   <= 1'b1;
              r_load   <= 1'b0;
            end
          end
          HEADER: begin
            if (w_rise) begin
              r_rx     <= w_byte;
              r_bitcnt <= r_bitcnt + 3'd1;
              if (w_last) begin
                if (w_is_cmd) begin
                  r_cmd_strobe <= 1'b1;
                  r_cmd        <= w_hdr_addr;
                  r_state      <= IGNORE;
                  r_miso       <= 1'b0;
                end else begin
                  r_rw    <= w_byte[7];
`ifdef CC1200_SPI_BURST_EN
                  r_burst <= w_byte[6];
`endif
                  r_addr  <= w_hdr_addr;
                  r_load  <= w_byte[7];
                  r_state <= DATA;
                end
              end
            end else if (w_fall) begin
              r_tx   <= {r_tx[6:0], 1'b0};
              r_miso <= r_tx[6];
            end
          end
          DATA: begin
            if (w_rise) begin
              r_rx     <= w_byte;
              r_bitcnt <= r_bitcnt + 3'd1;
              if (w_last) begin
                if (!r_rw && w_wr_ok) begin
                  r_regs[r_addr] <= w_byte;
                  r_wr_strobe    <= 1'b1;
                  r_wr_addr      <= r_addr;
                  r_wr_data      <= w_byte;
                end
`ifdef CC1200_SPI_BURST_EN
                if (r_burst) begin
                  r_addr <= r_addr + 6'd1;
                  r_load <= r_rw;
                end else begin
                  r_state <= IGNORE;
                  r_miso  <= 1'b0;
                end
`else
                r_state <= IGNORE;
                r_miso  <= 1'b0;
`endif
              end
            end else if (w_fall) begin
              if (r_load) begin
                r_tx   <= w_rd_data;
                r_miso <= w_rd_data[7];
                r_load <= 1'b0;
              end else begin
                r_tx   <= {r_tx[6:0], 1'b0};
                r_miso <= r_tx[6];
              end
            end
          end
          IGNORE: begin
            r_miso <= 1'b0;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign miso       = r_miso;
  assign miso_oe    = r_oe;
  assign busy       = r_busy;
  assign wr_strobe  = r_wr_strobe;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign cmd_strobe = r_cmd_strobe;
  assign cmd        = r_cmd;

endmodule
